basic_uart_tx_queue: RTL and testbench
======================================

Name: basic_uart_tx_queue

Overview:
- Byte FIFO plus issue FSM that sits directly upstream of basic_uart_transceiver's transmit side.
- Host logic pushes bytes at any rate. The block hands them to the transmitter one at a time using tx_ready, tx_wr_ev and tx_done_ev.
- Removes the need for the host to poll tx_ready, and absorbs bursts of up to DEPTH bytes.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 16 entries); legal range 1..8.
- DATA_W, 8, byte width; fixed at 8 for the transmitter interface.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  push request, one byte per cycle.
- wr_dat  input  8  byte to push.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries.
- level  output  DEPTH_LOG2+1  current entry count, 0..DEPTH.
- overflow  output  1  one-cycle pulse when a push is rejected.
- tx_ready  input  1  from transmitter: idle and able to accept a byte.
- tx_done_ev  input  1  from transmitter: one-cycle pulse when the stop bit(s) complete.
- tx_wr_ev  output  1  to transmitter: one-cycle start pulse.
- tx_dat  output  8  to transmitter: byte being sent.

Behaviour:
- Clock and reset: single clock domain, clk. rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - wr_ptr = rd_ptr = 0, level = 0.
  - empty = 1, full = 0, overflow = 0.
  - tx_wr_ev = 0, tx_dat = 8'h00.
  - FSM in IDLE.
  - RAM contents are not reset.
- Reset mid-operation:
  - Queue is discarded and the FSM returns to IDLE.
  - A byte already started in the transmitter is not tracked; any later tx_done_ev received in IDLE is ignored.
- FIFO storage:
  - DEPTH x 8 register array.
  - Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH.
  - level is a separate counter.
- Push: accepted when wr_en=1 and full=0. The byte is written at wr_ptr and wr_ptr increments.
- Push while full: rejected even if a pop occurs in the same cycle. Data is dropped and overflow pulses high for one cycle on the next edge. Pointers and level are unchanged.
- Pop: performed only by the FSM in the IDLE->ISSUE transition.
- Simultaneous accepted push and pop: level unchanged, both pointers advance.
- Flags and level are registered. full/empty/level reflect the state after the edge; a push at cycle N clears empty at N+1.
- FSM states:
  - IDLE: if empty=0 and tx_ready=1, then:
    - register tx_dat <= mem[rd_ptr];
    - advance rd_ptr and decrement level;
    - assert tx_wr_ev for the next cycle;
    - go to ISSUE.
  - ISSUE: tx_wr_ev=1 for exactly this one cycle; go to BUSY.
  - BUSY:
    - tx_dat held stable.
    - Wait for tx_done_ev=1, then go to GAP.
    - tx_ready is ignored in this state.
  - GAP: one dead cycle so the transmitter can re-raise tx_ready; go to IDLE.
- Latency: push at cycle N into an empty queue with tx_ready=1 gives empty=0 at N+1 and tx_wr_ev=1 at N+2.
- Back-to-back bytes: next tx_wr_ev no earlier than 2 cycles after tx_done_ev (GAP, then IDLE decision).
- Input handling: tx_done_ev outside BUSY is ignored. tx_wr_ev is never asserted while tx_ready=0.
- Stability: tx_dat changes only on the IDLE->ISSUE transition.

Optional Feature:
- Macro: BASIC_UART_TXQ_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush=1 synchronously resets wr_ptr, rd_ptr and level to 0, and sets empty=1, full=0.
  - A push in the same cycle as flush is discarded, with no overflow pulse.
  - The FSM is unaffected; a byte in ISSUE/BUSY completes normally.
- Not defined: no flush port; the FIFO is cleared only by rst.

Decomposition:
- Shared package basic_uart_pkg holds:
  - FSM state encoding: IDLE=2'd0, ISSUE=2'd1, BUSY=2'd2, GAP=2'd3;
  - UART_DATA_W = 8;
  - the default DEPTH_LOG2.
- One sub-module, basic_uart_sync_fifo: storage, pointers, level, full/empty, overflow.
- The issue FSM stays in basic_uart_tx_queue.
- basic_uart_sync_fifo is reused later for the RX-side queue.

Test Plan:
- Reset then idle, tx_ready=1: empty=1, level=0, tx_wr_ev never asserts over 100 cycles.
- Push 8'hA5 at cycle N, tx_ready=1: tx_wr_ev=1 at N+2 for exactly 1 cycle with tx_dat=8'hA5; tx_dat holds until tx_done_ev; level returns to 0.
- Push 8'h01..8'h03 back-to-back, transmitter model pulses tx_done_ev 20 cycles after each tx_wr_ev:
  - three tx_wr_ev pulses in order 01, 02, 03;
  - each is at least 2 cycles after the preceding tx_done_ev.
- tx_ready=0, push 17 bytes (DEPTH=16):
  - full=1 after the 16th push, level=16;
  - the 17th push gives a one-cycle overflow pulse and level stays 16;
  - then raise tx_ready and check bytes 1..16 drain in order.
- Wrap and concurrency: 40 random pushes interleaved with drains at DEPTH=4; scoreboard confirms order and level, and level never exceeds 4.
- BASIC_UART_TXQ_FLUSH_EN defined:
  - 5 bytes queued, first in BUSY, assert flush for 1 cycle;
  - the current byte completes, level=0, empty=1, no further tx_wr_ev.

Source files
------------

// File: rtl/basic_uart_pkg.sv
// Shared definitions for the basic UART blocks: data width, default queue
// depth and the transmit-queue issue FSM encoding.
package basic_uart_pkg;

    localparam int UART_DATA_W            = 8;
    localparam int TXQ_DEPTH_LOG2_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        GAP   = 2'd3
    } txq_state_t;

endpackage

// File: rtl/basic_uart_sync_fifo.sv
// Single-clock byte FIFO with registered flags, a separate level counter and
// a one-cycle overflow pulse for rejected pushes. Shared by the TX and RX
// queues. flush clears the pointers and level without touching the storage.
module basic_uart_sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_dat,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_dat,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;
    logic [DEPTH_LOG2:0]   level_nxt;

    // Decide which transfers actually happen this cycle and the resulting level.
    // A push while full is refused even if a pop frees a slot in the same cycle.
    always_comb begin
        push_ok   = wr_en && !full && !flush;
        pop_ok    = rd_en && !empty;
        level_nxt = level;
        if (push_ok && !pop_ok) begin
            level_nxt = level + 1'b1;
        end else if (pop_ok && !push_ok) begin
            level_nxt = level - 1'b1;
        end
    end

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers, level, registered flags and the overflow pulse.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level    <= level_nxt;
            empty    <= (level_nxt == '0);
            full     <= (level_nxt == DEPTH_CNT);
            overflow <= wr_en && full;
        end
    end

    assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/basic_uart_tx_queue.sv
// Byte queue in front of the UART transmitter. Bytes are pushed at any rate
// and issued one at a time with a start pulse, waiting for the transmitter's
// done pulse plus one dead cycle before the next byte.
// Optional macro BASIC_UART_TXQ_FLUSH_EN adds a flush input that empties the
// queue without disturbing a byte already handed to the transmitter.
module basic_uart_tx_queue
    import basic_uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = TXQ_DEPTH_LOG2_DEFAULT,
    parameter int DATA_W     = UART_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
`ifdef BASIC_UART_TXQ_FLUSH_EN
    input  logic                flush,
`endif
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wr_dat,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] level,
    output logic                overflow,
    input  logic                tx_ready,
    input  logic                tx_done_ev,
    output logic                tx_wr_ev,
    output logic [DATA_W-1:0]   tx_dat
);

    txq_state_t        state;
    logic              pop;
    logic              fifo_flush;
    logic [DATA_W-1:0] head_dat;

`ifdef BASIC_UART_TXQ_FLUSH_EN
    assign fifo_flush = flush;
`else
    assign fifo_flush = 1'b0;
`endif

    // The only pop is the IDLE->ISSUE hand-off, so tx_wr_ev never follows a
    // cycle where tx_ready was low.
    assign pop = (state == IDLE) && !empty && tx_ready;

    basic_uart_sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (fifo_flush),
        .wr_en    (wr_en),
        .wr_dat   (wr_dat),
        .rd_en    (pop),
        .rd_dat   (head_dat),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    // Issue FSM with registered start pulse and a byte register that only
    // loads on hand-off, so tx_dat stays stable for the whole transmission.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_wr_ev <= 1'b0;
            tx_dat   <= '0;
        end else begin
            tx_wr_ev <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_dat   <= head_dat;
                        tx_wr_ev <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= BUSY;
                end
                BUSY: begin
                    if (tx_done_ev) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_basic_uart_tx_queue.sv
// Directed bench for basic_uart_tx_queue: a 16-deep instance for the latency,
// ordering and full/overflow cases, plus a 4-deep instance for wrap traffic.
// Each instance is paired with a small transmitter model that checks issued
// bytes against a scoreboard queue filled by the stimulus.
module tb_basic_uart_tx_queue;

    logic       clk = 1'b0;
    logic       rst;

    logic       wr_en, tx_ready, tx_done_ev;
    logic [7:0] wr_dat;
    logic       full, empty, overflow, tx_wr_ev;
    logic [4:0] level;
    logic [7:0] tx_dat;

    logic       wr_en_4, tx_ready_4, tx_done_ev_4;
    logic [7:0] wr_dat_4;
    logic       full_4, empty_4, overflow_4, tx_wr_ev_4;
    logic [2:0] level_4;
    logic [7:0] tx_dat_4;

`ifdef BASIC_UART_TXQ_FLUSH_EN
    logic       flush;
    logic       flush_4;
`endif

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp4_q[$];

    // transmitter model state
    logic       ready_allow;
    logic       busy, busy_4;
    logic [7:0] held, held_4;
    int         cnt, cnt_4, dly_4;
    int         done_cyc, done_cyc_4;
    int         ev_count, ev_count_4;
    int         done_dly;

    basic_uart_tx_queue #(.DEPTH_LOG2(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
`ifdef BASIC_UART_TXQ_FLUSH_EN
        .flush      (flush),
`endif
        .wr_en      (wr_en),
        .wr_dat     (wr_dat),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .overflow   (overflow),
        .tx_ready   (tx_ready),
        .tx_done_ev (tx_done_ev),
        .tx_wr_ev   (tx_wr_ev),
        .tx_dat     (tx_dat)
    );

    basic_uart_tx_queue #(.DEPTH_LOG2(2)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
`ifdef BASIC_UART_TXQ_FLUSH_EN
        .flush      (flush_4),
`endif
        .wr_en      (wr_en_4),
        .wr_dat     (wr_dat_4),
        .full       (full_4),
        .empty      (empty_4),
        .level      (level_4),
        .overflow   (overflow_4),
        .tx_ready   (tx_ready_4),
        .tx_done_ev (tx_done_ev_4),
        .tx_wr_ev   (tx_wr_ev_4),
        .tx_dat     (tx_dat_4)
    );

    always #5 clk = ~clk;

    // cycle counter used to measure spacing between done and the next start
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [7:0] dat);
        @(negedge clk);
        wr_en  = en;
        wr_dat = dat;
    endtask

    task automatic waitDrain(input int budget);
        logic drained;
        drained = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && exp4_q.size() == 0 && !busy && !busy_4) begin
                drained = 1'b1;
                break;
            end
        end
        checkOutput("drain_done", drained, 1'b1);
    endtask

    // transmitter model for the 16-deep instance: accepts a start pulse,
    // checks the byte and its stability, pulses done after done_dly cycles
    always @(negedge clk) begin
        tx_done_ev = 1'b0;
        if (tx_wr_ev) begin
            ev_count++;
            checkOutput("wr_ev_while_ready", tx_ready, 1'b1);
            checkOutput("gap_after_done", (cyc - done_cyc) >= 2, 1'b1);
            checkOutput("wr_ev_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) checkOutput("tx_dat_order", tx_dat, exp_q.pop_front());
            busy     = 1'b1;
            held     = tx_dat;
            cnt      = 0;
            tx_ready = 1'b0;
        end else if (busy) begin
            checkOutput("tx_dat_hold", tx_dat, held);
            cnt++;
            if (cnt >= done_dly) begin
                tx_done_ev = 1'b1;
                busy       = 1'b0;
                done_cyc   = cyc;
            end
        end else begin
            tx_ready = ready_allow;
        end
    end

    // transmitter model for the 4-deep instance with a random service time
    always @(negedge clk) begin
        tx_done_ev_4 = 1'b0;
        if (tx_wr_ev_4) begin
            ev_count_4++;
            checkOutput("wr_ev4_while_ready", tx_ready_4, 1'b1);
            checkOutput("gap4_after_done", (cyc - done_cyc_4) >= 2, 1'b1);
            checkOutput("wr_ev4_expected", exp4_q.size() != 0, 1'b1);
            if (exp4_q.size() != 0) checkOutput("tx_dat4_order", tx_dat_4, exp4_q.pop_front());
            busy_4     = 1'b1;
            held_4     = tx_dat_4;
            cnt_4      = 0;
            dly_4      = $urandom_range(1, 4);
            tx_ready_4 = 1'b0;
        end else if (busy_4) begin
            checkOutput("tx_dat4_hold", tx_dat_4, held_4);
            cnt_4++;
            if (cnt_4 >= dly_4) begin
                tx_done_ev_4 = 1'b1;
                busy_4       = 1'b0;
                done_cyc_4   = cyc;
            end
        end else begin
            tx_ready_4 = 1'b1;
        end
    end

    initial begin
        int ev_before;
        int mlevel;
        int accepted;
        logic push_prev;
        logic seen;

        rst = 1'b1;
        wr_en = 1'b0; wr_dat = 8'h00; tx_ready = 1'b1; tx_done_ev = 1'b0;
        wr_en_4 = 1'b0; wr_dat_4 = 8'h00; tx_ready_4 = 1'b1; tx_done_ev_4 = 1'b0;
`ifdef BASIC_UART_TXQ_FLUSH_EN
        flush = 1'b0; flush_4 = 1'b0;
`endif
        ready_allow = 1'b1;
        busy = 1'b0; busy_4 = 1'b0; held = 8'h00; held_4 = 8'h00;
        cnt = 0; cnt_4 = 0; dly_4 = 1; done_cyc = -100; done_cyc_4 = -100;
        ev_count = 0; ev_count_4 = 0; done_dly = 20;

        // reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_empty", empty, 1'b1);
        checkOutput("rst_full", full, 1'b0);
        checkOutput("rst_level", level, 5'd0);
        checkOutput("rst_overflow", overflow, 1'b0);
        checkOutput("rst_tx_wr_ev", tx_wr_ev, 1'b0);
        checkOutput("rst_tx_dat", tx_dat, 8'h00);
        checkOutput("rst_level4", level_4, 3'd0);
        rst = 1'b0;

        // idle with transmitter ready: nothing may be issued
        repeat (100) @(negedge clk);
        checkOutput("idle_no_wr_ev", ev_count, 0);
        checkOutput("idle_empty", empty, 1'b1);
        checkOutput("idle_level", level, 5'd0);

        // single byte latency: push at N, empty clears at N+1, start at N+2
        applyStimulus(1'b1, 8'hA5);
        exp_q.push_back(8'hA5);
        applyStimulus(1'b0, 8'h00);
        checkOutput("lat_empty_n1", empty, 1'b0);
        checkOutput("lat_level_n1", level, 5'd1);
        checkOutput("lat_wr_ev_n1", tx_wr_ev, 1'b0);
        @(negedge clk);
        checkOutput("lat_wr_ev_n2", tx_wr_ev, 1'b1);
        checkOutput("lat_tx_dat_n2", tx_dat, 8'hA5);
        checkOutput("lat_level_n2", level, 5'd0);
        checkOutput("lat_empty_n2", empty, 1'b1);
        @(negedge clk);
        checkOutput("lat_wr_ev_n3", tx_wr_ev, 1'b0);
        waitDrain(100);
        checkOutput("single_ev_count", ev_count, 1);

        // three back-to-back bytes, 20-cycle transmitter
        ev_before = ev_count;
        applyStimulus(1'b1, 8'h01); exp_q.push_back(8'h01);
        applyStimulus(1'b1, 8'h02); exp_q.push_back(8'h02);
        applyStimulus(1'b1, 8'h03); exp_q.push_back(8'h03);
        applyStimulus(1'b0, 8'h00);
        waitDrain(200);
        checkOutput("burst3_ev_count", ev_count - ev_before, 3);
        checkOutput("burst3_level", level, 5'd0);

        // fill with transmitter held off, then overflow on the 17th push
        ready_allow = 1'b0;
        tx_ready    = 1'b0;
        done_dly    = 3;
        ev_before   = ev_count;
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1'b1, 8'h10 + 8'(i));
            if (i < 16) exp_q.push_back(8'h10 + 8'(i));
            if (i == 15) begin
                checkOutput("fill15_full", full, 1'b0);
                checkOutput("fill15_level", level, 5'd15);
            end
            if (i == 16) begin
                checkOutput("fill16_full", full, 1'b1);
                checkOutput("fill16_level", level, 5'd16);
                checkOutput("fill16_overflow", overflow, 1'b0);
            end
        end
        applyStimulus(1'b0, 8'h00);
        checkOutput("ovf_pulse", overflow, 1'b1);
        checkOutput("ovf_level", level, 5'd16);
        checkOutput("ovf_full", full, 1'b1);
        @(negedge clk);
        checkOutput("ovf_pulse_end", overflow, 1'b0);
        checkOutput("held_off_no_wr_ev", ev_count - ev_before, 0);
        ready_allow = 1'b1;
        waitDrain(600);
        checkOutput("drain16_ev_count", ev_count - ev_before, 16);
        checkOutput("drain16_level", level, 5'd0);
        checkOutput("drain16_empty", empty, 1'b1);

        // random pushes against a 4-deep queue with concurrent draining
        mlevel    = 0;
        accepted  = 0;
        push_prev = 1'b0;
        for (int c = 0; c < 3000 && accepted < 40; c++) begin
            @(negedge clk);
            mlevel = mlevel + (push_prev ? 1 : 0) - (tx_wr_ev_4 ? 1 : 0);
            checkOutput("wrap_level", level_4, mlevel);
            checkOutput("wrap_level_max", level_4 <= 3'd4, 1'b1);
            checkOutput("wrap_full", full_4, mlevel == 4);
            wr_en_4   = 1'($urandom_range(0, 1));
            wr_dat_4  = 8'h40 + 8'(accepted);
            push_prev = wr_en_4 && (mlevel != 4);
            if (push_prev) begin
                exp4_q.push_back(wr_dat_4);
                accepted++;
            end
        end
        @(negedge clk);
        wr_en_4 = 1'b0;
        mlevel  = mlevel + (push_prev ? 1 : 0) - (tx_wr_ev_4 ? 1 : 0);
        checkOutput("wrap_level_last", level_4, mlevel);
        checkOutput("wrap_accepted", accepted, 40);
        waitDrain(1000);
        checkOutput("wrap_ev_count", ev_count_4, 40);
        checkOutput("wrap_level_end", level_4, 3'd0);

`ifdef BASIC_UART_TXQ_FLUSH_EN
        // flush while the first of five bytes is in flight
        done_dly  = 20;
        ev_before = ev_count;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'hC0 + 8'(i));
            exp_q.push_back(8'hC0 + 8'(i));
        end
        applyStimulus(1'b0, 8'h00);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (busy) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("flush_first_busy", seen, 1'b1);
        flush = 1'b1;
        exp_q.delete();
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_level", level, 5'd0);
        checkOutput("flush_empty", empty, 1'b1);
        checkOutput("flush_full", full, 1'b0);
        checkOutput("flush_still_busy", busy, 1'b1);
        waitDrain(100);
        repeat (40) @(negedge clk);
        checkOutput("flush_ev_count", ev_count - ev_before, 1);
        checkOutput("flush_level_end", level, 5'd0);
        checkOutput("flush_empty_end", empty, 1'b1);
`else
        seen = 1'b0;
        checkOutput("no_flush_level", level, 5'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
